// File: rtl/rv_pkg.sv
// Shared RISC-V constants: major opcodes, the canonical NOP and the fetch FSM state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding memory fetch and inline field decode.
// Optional macro FETCH_MISALIGN_EN: reject targets with bit1 set and raise a sticky misalign flag.
//
// state   | meaning
// FS_IDLE | no fetch outstanding; PC updates apply on the next edge
// FS_REQ  | mem_req held at pc until mem_ack; PC updates are buffered
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        pc_sel,
  input  logic [31:0] target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        misalign
);

  fetch_state_e state, state_nxt;

  logic        upd;
  logic [31:0] sel_val, upd_val;
  logic        pend_vld;
  logic [31:0] pend_val;
  logic        ack_done;
  logic        load_en;
  logic [31:0] load_val;
  logic        mis_hit;

  assign pc_plus4 = pc + 32'd4;
  assign mem_addr = pc;
  assign upd      = pc_write | (branch & branch_taken);
  assign ack_done = (state == FS_REQ) & mem_ack;
  assign sel_val  = pc_sel ? (target & 32'hFFFF_FFFE) : pc_plus4;

`ifdef FETCH_MISALIGN_EN
  assign upd_val = sel_val;
  assign mis_hit = load_en & load_val[1];
`else
  assign upd_val = sel_val & 32'hFFFF_FFFC;
  assign mis_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= FS_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE: if (fetch_start) state_nxt = FS_REQ;
      FS_REQ:  if (mem_ack)     state_nxt = FS_IDLE;
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    mem_req = 1'b0;
    if (state == FS_REQ) begin
      busy    = 1'b1;
      mem_req = 1'b1;
    end
  end

  // An update arriving in the same cycle as the ack is the latest one and wins over the buffer.
  always_comb begin
    load_en  = 1'b0;
    load_val = pc;
    if (state == FS_IDLE) begin
      load_en  = upd;
      load_val = upd_val;
    end else if (ack_done) begin
      if (upd) begin
        load_en  = 1'b1;
        load_val = upd_val;
      end else if (pend_vld) begin
        load_en  = 1'b1;
        load_val = pend_val;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend_vld <= 1'b0;
      pend_val <= 32'h0;
    end else if (state == FS_REQ && !mem_ack) begin
      if (upd) begin
        pend_vld <= 1'b1;
        pend_val <= upd_val;
      end
    end else begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      if (load_en && !mis_hit) pc <= load_val;
      if (mis_hit) misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir       <= INSN_NOP;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= ack_done;
      if (ack_done) ir <= mem_rdata;
    end
  end

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign func3  = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: fetches push expected instructions, a monitor checks each ir_valid pulse.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        fetch_start, pc_write, branch, branch_taken, pc_sel;
  logic [31:0] target;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] pc, pc_plus4, ir;
  logic        ir_valid, busy, misalign;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;

  typedef struct {
    logic [31:0] insn;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clr(clr), .fetch_start(fetch_start), .pc_write(pc_write),
    .branch(branch), .branch_taken(branch_taken), .pc_sel(pc_sel), .target(target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .ir_valid(ir_valid), .busy(busy),
    .opcode(opcode), .func3(func3), .rd(rd), .rs1(rs1), .rs2(rs2), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] insn, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    exp_t e;
    e.insn = insn; e.opc = opc; e.f3 = f3; e.rd = d; e.rs1 = s1; e.rs2 = s2;
    exp_q.push_back(e);
  endtask

  task automatic upd_pc(input logic pw, input logic br, input logic tk, input logic sel,
                        input logic [31:0] tgt);
    pc_write = pw; branch = br; branch_taken = tk; pc_sel = sel; target = tgt;
    step();
    pc_write = 1'b0; branch = 1'b0; branch_taken = 1'b0; pc_sel = 1'b0; target = 32'h0;
  endtask

  task automatic ack(input logic [31:0] data);
    mem_ack = 1'b1; mem_rdata = data;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // Monitor: every ir_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ir_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ir_valid: got ir %h expected no fetch result", ir);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ir", ir, e.insn);
        chk("opcode", {25'h0, opcode}, {25'h0, e.opc});
        chk("func3", {29'h0, func3}, {29'h0, e.f3});
        chk("rd", {27'h0, rd}, {27'h0, e.rd});
        chk("rs1", {27'h0, rs1}, {27'h0, e.rs1});
        chk("rs2", {27'h0, rs2}, {27'h0, e.rs2});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; fetch_start = 1'b0; pc_write = 1'b0; branch = 1'b0; branch_taken = 1'b0;
    pc_sel = 1'b0; target = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    clr = 1'b1;
    step();

    // Basic fetch at 0x0, ack two cycles after the request.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("f1_req", {31'h0, mem_req}, 32'h1);
    chk("f1_busy", {31'h0, busy}, 32'h1);
    chk("f1_addr", mem_addr, 32'h0);
    fetch_start = 1'b1;           // ignored while busy
    step();
    fetch_start = 1'b0;
    chk("f1_addr_hold", mem_addr, 32'h0);
    push(32'h0050_0093, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd5);
    ack(32'h0050_0093);
    chk("f1_idle", {31'h0, busy}, 32'h0);
    step();
    chk("f1_valid_one_cycle", {31'h0, ir_valid}, 32'h0);
    chk("f1_no_queued_fetch", {31'h0, mem_req}, 32'h0);

    // PC updates in IDLE.
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'h10);
    chk("set_pc_10", pc, 32'h10);
    upd_pc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc_plus4_14", pc, 32'h14);
    upd_pc(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("branch_not_taken", pc, 32'h14);
    upd_pc(1'b0, 1'b1, 1'b1, 1'b1, 32'h20);
    chk("branch_taken_20", pc, 32'h20);

    // Branch during REQ is buffered; mem_addr holds.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("f2_addr", mem_addr, 32'h20);
    upd_pc(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    chk("f2_addr_hold", mem_addr, 32'h20);
    chk("f2_pc_hold", pc, 32'h20);
    push(32'h0020_8133, 7'b0110011, 3'd0, 5'd2, 5'd1, 5'd2);
    ack(32'h0020_8133);
    step();
    chk("f2_pc_after", pc, 32'h40);

    // Two buffered updates: the latest wins.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
    chk("f3_addr_hold", mem_addr, 32'h40);
    push(32'h0000_006f, 7'b1101111, 3'd0, 5'd0, 5'd0, 5'd0);
    ack(32'h0000_006f);
    step();
    chk("f3_latest_wins", pc, 32'h60);

    // Update coincident with fetch_start: fetch goes to the new pc.
    fetch_start = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    step();
    fetch_start = 1'b0; pc_write = 1'b0;
    chk("f4_pc", pc, 32'h64);
    chk("f4_addr", mem_addr, 32'h64);
    push(32'h0000_0093, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0);
    ack(32'h0000_0093);
    step();

    // 32-bit wrap of pc+4.
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_plus4_comb", pc_plus4, 32'h0);
    upd_pc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Target with bit1 set.
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_EN
    chk("misalign_pc", pc, 32'h0);
    chk("misalign_flag", {31'h0, misalign}, 32'h1);
    upd_pc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    chk("misalign_sticky", {31'h0, misalign}, 32'h1);
`else
    chk("misalign_pc", pc, 32'h100);
    chk("misalign_flag", {31'h0, misalign}, 32'h0);
`endif

    // Reset mid-REQ, then a late ack after release.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("f5_busy", {31'h0, busy}, 32'h1);
    clr = 1'b0;
    #1;
    chk("clr_pc", pc, 32'h0);
    chk("clr_mem_req", {31'h0, mem_req}, 32'h0);
    chk("clr_ir", ir, 32'h0000_0013);
    chk("clr_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    step();
    ack(32'hDEAD_BEEF);
    chk("late_ack_busy", {31'h0, busy}, 32'h0);
    step();
    chk("late_ack_ir", ir, 32'h0000_0013);
    chk("late_ack_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("late_ack_pc", pc, 32'h0);
    step();

    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: fetch_start  input  1  request one instruction fetch at current PC (control state 0).
REQ-005 SHALL have port: pc_write  input  1  unconditional PC update.
REQ-006 SHALL have port: branch  input  1  conditional PC update, qualified by branch_taken.
REQ-007 SHALL have port: branch_taken  input  1  comparator result for current branch.
REQ-008 SHALL have port: pc_sel  input  1  0 selects pc+4, 1 selects target.
REQ-009 SHALL have port: target  input  32  jump/branch target address.
REQ-010 SHALL have ports: mem_req output 1, mem_addr output 32, mem_ack input 1, mem_rdata input 32; instruction memory handshake.
REQ-011 SHALL have ports: pc output 32, pc_plus4 output 32, ir output 32, ir_valid output 1, busy output 1.
REQ-012 SHALL have decode ports (all outputs, combinational from ir): opcode 7, func3 3, rd 5, rs1 5, rs2 5.
REQ-013 SHALL have port: misalign  output  1  sticky misaligned-target flag.

Function
REQ-014 SHALL implement FSM IDLE, REQ; busy=1 exactly in REQ.
REQ-015 IDLE: fetch_start=1 SHALL move to REQ next cycle; otherwise stay.
REQ-016 REQ: mem_req=1, mem_addr=pc, held stable until mem_ack=1.
REQ-017 REQ with mem_ack=1: ir<=mem_rdata, return to IDLE; ir_valid SHALL be 1 for exactly the following cycle.
REQ-018 fetch_start while busy SHALL be ignored (no queueing).
REQ-019 PC update event = pc_write | (branch & branch_taken); branch & !branch_taken SHALL leave PC unchanged.
REQ-020 Update value: pc_sel=0 -> pc+4; pc_sel=1 -> {target[31:1],1'b0}; 32-bit wrap-around, no carry out.
REQ-021 Update event in IDLE SHALL apply next edge.
REQ-022 Update event in REQ SHALL be buffered (one entry, latest wins) and applied on the edge after mem_ack; mem_addr unaffected.
REQ-023 Update event coincident with fetch_start in IDLE: PC updates, fetch issues at the NEW pc.
REQ-024 pc_plus4 SHALL equal pc+4 combinationally.

Reset
REQ-025 clr=0 SHALL immediately force: pc=RESET_PC, ir=32'h0000_0013 (NOP), state IDLE, ir_valid=0, mem_req=0, misalign=0, pending update cleared.
REQ-026 Reset mid-REQ SHALL abandon the fetch; a late mem_ack after release SHALL be ignored.

Configuration
REQ-027 Macro FETCH_MISALIGN_EN defined: update value with bit1=1 SHALL NOT load pc; misalign set, sticky until clr.
REQ-028 Macro undefined: bits [1:0] of selected target forced 00; misalign tied 0.

Structure
REQ-029 Shared package rv_pkg SHALL hold opcode constants, NOP constant, fetch FSM state typedef.
REQ-030 No sub-module; field decode inline.

Verification
REQ-031 Reset, fetch_start, ack after 2 cycles with 0x00500093 -> mem_addr=0x0, ir=0x00500093, opcode=0010011, rd=1, ir_valid one cycle.
REQ-032 pc=0x10, pc_write=1, pc_sel=0 -> pc=0x14; branch=1, taken=0 -> pc stays 0x14.
REQ-033 In REQ at pc=0x20, branch=1, taken=1, target=0x40 -> mem_addr stays 0x20 until ack, pc=0x40 after.
REQ-034 pc=0xFFFFFFFC, pc_sel=0 update -> pc=0x0.
REQ-035 FETCH_MISALIGN_EN, target=0x102 -> pc unchanged, misalign=1; undefined -> pc=0x100.
REQ-036 clr low during REQ, ack one cycle after release -> pc=RESET_PC, ir=0x13, ir_valid=0.
